// File: rtl/conv_sequencer_pkg.sv
// Shared definitions for the convolution layer sequencer: layer/mode types,
// sequencer state encoding and the per-batch operating-mode rule.
package conv_sequencer_pkg;

    localparam int unsigned BATCH_W = 6;

    typedef enum logic [2:0] {
        NULL   = 3'd0,
        LAYER1 = 3'd1,
        LAYER2 = 3'd2,
        LAYER3 = 3'd3,
        LAYER4 = 3'd4,
        LAYER5 = 3'd5
    } LAYER_TYPE;

    typedef enum logic [1:0] {
        MODE1 = 2'd0,
        MODE2 = 2'd1,
        MODE3 = 2'd2,
        MODE4 = 2'd3
    } OP_MODE;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_DATA = 3'd2,
        CONV      = 3'd3,
        RUN       = 3'd4,
        DONE      = 3'd5,
        ERROR     = 3'd6
    } CONV_SEQ_STATE;

    // Padded layers: first batch MODE3, the rest MODE4.
    // Unpadded layers: MODE1 except the last batch (MODE2); a single batch is MODE2.
    function automatic OP_MODE select_mode(
        input logic               pad_en,
        input logic [BATCH_W-1:0] idx,
        input logic [BATCH_W-1:0] last
    );
        if (pad_en) begin
            return (idx == '0) ? MODE3 : MODE4;
        end
        return (idx == last) ? MODE2 : MODE1;
    endfunction

endpackage

// File: rtl/conv_sequencer_watchdog.sv
// Loadable down-counter guarding the RUN phase; expire is asserted during the
// last permitted enabled cycle after a load.
module seq_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic load,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (enable && (count != '0)) begin
            count <= count - ONE;
        end
    end

    assign expire = enable && (count == '0);

endmodule

// File: rtl/conv_sequencer.sv
// Layer-level controller: issues the NOC layer start, then walks the ifmap
// batches through WAIT_DATA/CONV/RUN with a watchdog on the RUN phase.
module conv_sequencer
    import conv_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned MAX_BATCHES    = 63
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               layer_start,
    input  LAYER_TYPE          layer_type_in,
    input  logic [BATCH_W-1:0] num_batches_in,
    input  logic               pad_en_in,
    input  logic               abort,
    input  logic               ifmap_valid_in,
    input  logic               free_ifmap_buffer,
    output logic               noc_start,
    output LAYER_TYPE          noc_layer_type,
    output logic               noc_start_conv,
    output OP_MODE             noc_mode,
    output logic               ifmap_pop,
    output logic [BATCH_W-1:0] batch_idx,
    output logic               busy,
    output logic               layer_done,
    output logic               timeout_err,
    output logic [31:0]        conv_cycles
);

    localparam logic [BATCH_W-1:0] NUM_MAX = BATCH_W'(MAX_BATCHES);
    localparam logic [BATCH_W-1:0] ONE     = BATCH_W'(1);

    CONV_SEQ_STATE      state;
    CONV_SEQ_STATE      state_next;
    logic               accept;
    logic               freed;
    logic               wd_expire;
    logic               pad_q;
    logic [BATCH_W-1:0] last_q;
    logic [BATCH_W-1:0] last_in;

    always_comb begin
        if (num_batches_in == '0) begin
            last_in = '0;
        end else if (num_batches_in > NUM_MAX) begin
            last_in = NUM_MAX - ONE;
        end else begin
            last_in = num_batches_in - ONE;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE, DONE, ERROR: begin
                if (layer_start) begin
                    state_next = START;
                    accept     = 1'b1;
                end
            end
            START: state_next = WAIT_DATA;
            // During the pop cycle the buffer still flags the batch just released.
            WAIT_DATA: begin
                if (ifmap_valid_in && !ifmap_pop) begin
                    state_next = CONV;
                end
            end
            CONV: state_next = RUN;
            RUN: begin
                if (free_ifmap_buffer) begin
                    state_next = (batch_idx == last_q) ? DONE : WAIT_DATA;
                end else if (wd_expire) begin
                    state_next = ERROR;
                end
            end
            default: state_next = IDLE;
        endcase
        if (abort) begin
            state_next = IDLE;
            accept     = 1'b0;
        end
    end

    assign freed = (state == RUN) && free_ifmap_buffer && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            noc_start      <= 1'b0;
            noc_start_conv <= 1'b0;
            ifmap_pop      <= 1'b0;
            layer_done     <= 1'b0;
            busy           <= 1'b0;
            timeout_err    <= 1'b0;
            batch_idx      <= '0;
            conv_cycles    <= '0;
            noc_layer_type <= NULL;
            noc_mode       <= MODE1;
            pad_q          <= 1'b0;
            last_q         <= '0;
        end else begin
            state          <= state_next;
            noc_start      <= (state_next == START);
            noc_start_conv <= (state_next == CONV);
            ifmap_pop      <= freed;
            layer_done     <= freed && (batch_idx == last_q);
            busy           <= !(state_next inside {IDLE, DONE, ERROR});
            if (state_next == CONV) begin
                noc_mode <= select_mode(pad_q, batch_idx, last_q);
            end
            if (accept) begin
                noc_layer_type <= layer_type_in;
                pad_q          <= pad_en_in;
                last_q         <= last_in;
                batch_idx      <= '0;
                conv_cycles    <= '0;
                timeout_err    <= 1'b0;
            end else begin
                if (abort) begin
                    batch_idx <= '0;
                end else if (freed && (batch_idx != last_q)) begin
                    batch_idx <= batch_idx + ONE;
                end
                if ((state inside {WAIT_DATA, CONV, RUN}) && (conv_cycles != '1)) begin
                    conv_cycles <= conv_cycles + 32'd1;
                end
                if ((state == RUN) && (state_next == ERROR)) begin
                    timeout_err <= 1'b1;
                end
            end
        end
    end

    seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (abort),
        .load   (state == CONV),
        .enable (state == RUN),
        .expire (wd_expire)
    );

endmodule
